// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C target: state encoding, widths, ACK levels
// and the bit-order aware shift helpers.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sh, input logic b,
                                                 input logic lsb_first);
    return lsb_first ? {b, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], b};
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] sh,
                                                  input logic lsb_first);
    return lsb_first ? {1'b0, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb_first);
    return lsb_first ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= 4'd8) ? 4'd8 : c + 4'd1;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes scl_in/sda_in and derives SCL edges plus START/STOP conditions.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sh;
  logic [SYNC_STAGES-1:0] sda_sh;
  logic scl_s;
  logic scl_d;
  logic sda_d;

  // Clearing to 0 means a released bus after reset looks like a rise, never a false START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sh <= '0;
      sda_sh <= '0;
      scl_d  <= 1'b0;
      sda_d  <= 1'b0;
    end else begin
      scl_sh <= {scl_sh[SYNC_STAGES-2:0], scl_in};
      sda_sh <= {sda_sh[SYNC_STAGES-2:0], sda_in};
      scl_d  <= scl_s;
      sda_d  <= sda_s;
    end
  end

  assign scl_s     = scl_sh[SYNC_STAGES-1];
  assign sda_s     = sda_sh[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target responder: address match, write receive and read supply with ACK handling.
// Optional SCL stretching on read byte boundaries is enabled by I2C_SLAVE_CLK_STRETCH_EN.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'b1001100,
  parameter int         LSB_FIRST   = 0,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  input  logic       tx_valid,
`endif
  output logic       tx_ready,
  output logic       addr_match,
  output logic       rw_dir,
  output logic       busy
);

  localparam logic LSB = (LSB_FIRST != 0);

  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shifter;
  logic [7:0] shift_nxt;
  logic [7:0] tx_nxt;
  logic [6:0] addr_rx;
  logic       rw_rx;
  logic       reload_req;
  logic       load_go;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  assign shift_nxt = shift_in(shifter, sda_s, LSB);
  assign tx_nxt    = shift_out(shifter, LSB);
  assign addr_rx   = LSB ? shift_nxt[6:0] : shift_nxt[7:1];
  assign rw_rx     = LSB ? shift_nxt[7] : shift_nxt[0];

  // A read byte boundary: end of the address ACK on a read, or a master ACK on read data.
  assign reload_req = scl_fall && (bit_cnt == 4'd1) &&
                      ((state == ADDR_ACK && rw_dir) || state == RD_ACK);

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic stretching;
  logic scl_hold;
  logic stretch_go;

  assign scl_oe     = scl_hold;
  assign load_go    = stretching ? tx_valid : (reload_req && tx_valid);
  assign stretch_go = reload_req && !tx_valid && !stretching;
`else
  assign scl_oe  = 1'b0;
  assign load_go = reload_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shifter    <= 8'd0;
      sda_oe     <= 1'b0;
      rx_data    <= 8'd0;
      rx_valid   <= 1'b0;
      tx_ready   <= 1'b0;
      addr_match <= 1'b0;
      rw_dir     <= 1'b0;
      busy       <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      stretching <= 1'b0;
      scl_hold   <= 1'b0;
`endif
    end else begin
      rx_valid   <= 1'b0;
      tx_ready   <= 1'b0;
      addr_match <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        busy    <= 1'b1;
        sda_oe  <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        stretching <= 1'b0;
        scl_hold   <= 1'b0;
`endif
      end else if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= 4'd0;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        stretching <= 1'b0;
        scl_hold   <= 1'b0;
`endif
      end else if (load_go) begin
        tx_ready <= 1'b1;
        shifter  <= tx_data;
        sda_oe   <= ~first_bit(tx_data, LSB);
        bit_cnt  <= 4'd0;
        state    <= RD_DATA;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        stretching <= 1'b0;
`endif
      end else begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        // A hold that is not waiting on tx_valid lasts exactly one clk.
        if (scl_hold && !stretching) scl_hold <= 1'b0;
        if (stretch_go) begin
          scl_hold   <= 1'b1;
          stretching <= 1'b1;
        end
`endif
        case (state)
          IDLE: begin
          end
          ADDR: begin
            if (scl_rise) begin
              shifter <= shift_nxt;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                if (addr_rx == SLAVE_ADDR) begin
                  rw_dir     <= rw_rx;
                  addr_match <= 1'b1;
                  state      <= ADDR_ACK;
                end else begin
                  state <= WAIT_STOP;
                end
              end else begin
                bit_cnt <= sat_inc(bit_cnt);
              end
            end
          end
          ADDR_ACK, WR_ACK: begin
            // bit_cnt 0 = waiting to drive ACK, 1 = ACK on the bus until the next fall.
            if (scl_fall) begin
              if (bit_cnt == 4'd0) begin
                sda_oe  <= 1'b1;
                bit_cnt <= 4'd1;
              end else if (!rw_dir) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= WR_DATA;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                scl_hold <= 1'b1;
`endif
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shifter <= shift_nxt;
              if (bit_cnt == 4'd7) begin
                rx_data  <= shift_nxt;
                rx_valid <= 1'b1;
                bit_cnt  <= 4'd0;
                state    <= WR_ACK;
              end else begin
                bit_cnt <= sat_inc(bit_cnt);
              end
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= RD_ACK;
              end else begin
                shifter <= tx_nxt;
                sda_oe  <= ~first_bit(tx_nxt, LSB);
                bit_cnt <= sat_inc(bit_cnt);
              end
            end
          end
          RD_ACK: begin
            // The reload on the following fall is taken by load_go above.
            if (scl_rise && bit_cnt == 4'd0) begin
              if (sda_s == NACK) state <= WAIT_STOP;
              else bit_cnt <= 4'd1;
            end
          end
          WAIT_STOP: begin
            sda_oe <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
